// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction-memory bus and instruction stream of the fetch unit.
//   imem_req/imem_addr    : fetch request and byte address (fetch side drives)
//   imem_ack/imem_rdata   : request accepted, read data valid in the same cycle
//   pc/instruction        : fetched instruction and its address (fetch side drives)
//   instr_valid/instr_ready : valid/ready handshake towards the CPU
// modport master = fetch unit, modport slave = memory + CPU side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, pc, instruction, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, pc, instruction, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetcher with branch redirect and halt.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   start           : leave IDLE and begin fetching at RESET_PC
//   stall           : hold off new memory requests (never aborts one in flight)
//   branch_taken/branch_target : redirect the fetch stream
//   halted, align_err : status flags (DONE reached, misaligned branch target)
//   bus             : fetch_unit_if.master (imem request bus + instruction stream)
// Optional feature: define FETCH_ALIGN_CHECK_EN to halt with align_err on a
// branch target whose low two bits are non-zero; otherwise those bits are
// cleared and align_err stays 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'h0000_001C
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_target,
    output logic                halted,
    output logic                align_err,
    fetch_unit_if.master        bus
);
    typedef enum logic [2:0] {IDLE, REQ, HOLD, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        kill;          // outstanding request was redirected; drop its data
    logic [31:0] kill_target;   // where to go once the killed request is acked
    logic [31:0] target;
    logic        bad_target;
    logic        handshake;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
    assign target = branch_target;
`else
    localparam bit ALIGN_CHECK = 1'b0;
    assign target = {branch_target[31:2], 2'b00};
`endif

    assign bad_target   = ALIGN_CHECK && (branch_target[1:0] != 2'b00);
    assign handshake    = bus.instr_valid && bus.instr_ready;
    assign bus.imem_req = (state == REQ);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ: begin
                if (branch_taken && bad_target)
                    state_nxt = DONE;
                else if (bus.imem_ack && !kill && !branch_taken)
                    state_nxt = HOLD;
                // killed or redirected-on-ack requests reissue from REQ
            end
            HOLD, WAIT: begin
                // a branch wins over both the +4 stream and the PC_LIMIT halt
                if (branch_taken)
                    state_nxt = bad_target ? DONE : (stall ? WAIT : REQ);
                else if (state == HOLD) begin
                    if (handshake)
                        state_nxt = (bus.pc == PC_LIMIT) ? DONE : (stall ? WAIT : REQ);
                end else if (!stall)
                    state_nxt = REQ;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // imem_addr always holds the next address to fetch, so it is stable
    // throughout REQ until the ack arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.pc          <= RESET_PC;
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            bus.imem_addr   <= RESET_PC;
            kill            <= 1'b0;
            kill_target     <= '0;
            halted          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) bus.imem_addr <= RESET_PC;
                REQ: begin
                    if (branch_taken) begin
                        if (bus.imem_ack) begin
                            bus.imem_addr <= target;
                            kill          <= 1'b0;
                        end else begin
                            kill          <= 1'b1;
                            kill_target   <= target;
                        end
                    end else if (bus.imem_ack) begin
                        if (kill) begin
                            bus.imem_addr <= kill_target;
                            kill          <= 1'b0;
                        end else begin
                            bus.instruction <= bus.imem_rdata;
                            bus.pc          <= bus.imem_addr;
                            bus.instr_valid <= 1'b1;
                            bus.imem_addr   <= bus.imem_addr + 32'd4;
                        end
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        bus.instr_valid <= 1'b0;
                        bus.imem_addr   <= target;
                    end else if (handshake)
                        bus.instr_valid <= 1'b0;
                end
                WAIT: if (branch_taken) bus.imem_addr <= target;
                default: ;
            endcase
            if (state_nxt == DONE) halted <= 1'b1;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset)
            align_err <= 1'b0;
        else if (branch_taken && bad_target && (state inside {REQ, HOLD, WAIT}))
            align_err <= 1'b1;
    end
`else
    assign align_err = 1'b0;
`endif
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after start.
REQ-002 Parameter PC_LIMIT, default 32'h0000_001C, address of last instruction fetched before halting.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  synchronous, active-low reset.
REQ-005 Port start  in  1  begin fetching; effective only in IDLE.
REQ-006 Port stall  in  1  inhibit issue of new memory requests.
REQ-007 Port branch_taken  in  1 and branch_target  in  32  redirect fetch stream.
REQ-008 Port imem_req  out  1, imem_addr  out  32  instruction-memory request and byte address.
REQ-009 Port imem_ack  in  1, imem_rdata  in  32  request accepted, data valid same cycle.
REQ-010 Port pc  out  32, instruction  out  32, instr_valid  out  1, instr_ready  in  1  instruction stream to CPU.
REQ-011 Port halted  out  1 and align_err  out  1  status flags.

Function
REQ-012 FSM states SHALL be IDLE, REQ, HOLD, WAIT, DONE.
REQ-013 IDLE: start=1 -> REQ next cycle with imem_addr=RESET_PC; otherwise stay.
REQ-014 REQ: imem_req=1; imem_addr SHALL remain stable until the cycle imem_ack=1.
REQ-015 REQ with imem_ack=1 and no kill: instruction<=imem_rdata, pc<=imem_addr, instr_valid<=1, next address<=imem_addr+4, go HOLD; one-cycle latency from ack to instr_valid.
REQ-016 HOLD: instruction, pc, instr_valid=1 stable until instr_valid&&instr_ready.
REQ-017 HOLD handshake: instr_valid<=0; if pc==PC_LIMIT -> DONE; else if stall -> WAIT; else -> REQ.
REQ-018 WAIT: imem_req=0; when stall=0 -> REQ next cycle.
REQ-019 stall SHALL NOT abort an outstanding request in REQ; it completes to HOLD normally.
REQ-020 Branch in HOLD or WAIT: held instruction dropped (instr_valid<=0), next address<=branch_target, -> REQ, or -> WAIT if stall=1.
REQ-021 Branch in HOLD coincident with handshake: instruction counts as consumed; branch_target overrides both the +4 address and the PC_LIMIT halt check.
REQ-022 Branch in REQ without ack: set kill flag, latch target; keep imem_addr stable; on ack discard imem_rdata, clear kill, reissue at latched target.
REQ-023 Branch in REQ coincident with ack: data discarded, imem_addr<=branch_target, stay REQ.
REQ-024 Later branch while kill set overwrites latched target.
REQ-025 Address arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-026 DONE: halted=1, imem_req=0, instr_valid=0; start and branch_taken ignored; exit only by reset.
REQ-027 start outside IDLE SHALL be ignored.

Reset
REQ-028 reset=0 at a rising edge: state<=IDLE, pc<=RESET_PC, instruction<=0, instr_valid<=0, imem_req<=0, imem_addr<=RESET_PC, kill<=0, halted<=0, align_err<=0.
REQ-029 Reset mid-request abandons it; an imem_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN defined: branch_target[1:0]!=0 sets align_err=1 (sticky until reset) and enters DONE next cycle without issuing the request.
REQ-031 Macro undefined: branch_target[1:0] forced to 2'b00; align_err tied 0.

Verification
REQ-032 Reset, start, imem_ack each REQ cycle, instr_ready=1 -> pc sequence 0,4,...,0x1C, then halted=1, imem_req=0.
REQ-033 imem_ack delayed 3 cycles at addr 0x8 -> imem_addr held at 0x8 for all 4 REQ cycles; instruction=imem_rdata of ack cycle.
REQ-034 Branch to 0x40 in REQ without ack at addr 0x4 -> returning data discarded, no instr_valid for 0x4, next imem_addr=0x40.
REQ-035 stall=1 during HOLD handshake at pc 0x4 for 5 cycles -> imem_req=0 for those cycles, then request at 0x8.
REQ-036 Branch to 0x12 at pc 0x10: with FETCH_ALIGN_CHECK_EN -> align_err=1, halted=1; without -> next imem_addr=0x10.
REQ-037 reset=0 while in REQ at 0xC with ack asserted -> next cycle IDLE, instr_valid=0, pc=RESET_PC.
